// File: rtl/lampfpu_div_seq.sv
// ---------------------------------------------------------------------------
// lampfpu_div_seq
//
// Iterative restoring floating-point divider.  It takes the same unpacked
// operand bundle as the FPU multiplier and returns the same pre-rounding
// result bundle.  The shared round/pack stage can therefore consume it without
// changes.  The divider retires one quotient bit per clock.
//
// Ports
//   clk, rst                 clock, synchronous active-low reset
//   doDiv_i                  start pulse; operands are sampled in that cycle
//   s_op*_i                  operand signs (op1 = dividend, op2 = divisor)
//   extShF_op*_i             normalized mantissas, hidden bit at the MSB
//   extE_op*_i               extended exponents
//   nlz_op*_i                normalization shift already applied to mantissa
//   isZ/isInf/isSNAN/isQNAN  operand class flags
//   s_res_o, e_res_o         result sign and exponent
//   f_res_o                  {ovf(0), hidden, fraction, G, R, S}
//   valid_o                  one-cycle completion strobe
//   busy_o                   high while an operation is in flight
//   isOverflow_o, isUnderflow_o, isToRound_o   flags for the rounder
// ---------------------------------------------------------------------------
module lampfpu_div_seq #(
    parameter int LAMP_FLOAT_F_DW   = 7,
    parameter int LAMP_FLOAT_E_DW   = 8,
    parameter int LAMP_FLOAT_E_BIAS = 127,
    parameter int LAMP_FLOAT_E_MAX  = 255
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  doDiv_i,
    input  logic                                  s_op1_i,
    input  logic [LAMP_FLOAT_F_DW:0]              extShF_op1_i,
    input  logic [LAMP_FLOAT_E_DW:0]              extE_op1_i,
    input  logic [$clog2(1+LAMP_FLOAT_F_DW)-1:0]  nlz_op1_i,
    input  logic                                  isZ_op1_i,
    input  logic                                  isInf_op1_i,
    input  logic                                  isSNAN_op1_i,
    input  logic                                  isQNAN_op1_i,
    input  logic                                  s_op2_i,
    input  logic [LAMP_FLOAT_F_DW:0]              extShF_op2_i,
    input  logic [LAMP_FLOAT_E_DW:0]              extE_op2_i,
    input  logic [$clog2(1+LAMP_FLOAT_F_DW)-1:0]  nlz_op2_i,
    input  logic                                  isZ_op2_i,
    input  logic                                  isInf_op2_i,
    input  logic                                  isSNAN_op2_i,
    input  logic                                  isQNAN_op2_i,
    output logic                                  s_res_o,
    output logic [LAMP_FLOAT_E_DW-1:0]            e_res_o,
    output logic [LAMP_FLOAT_F_DW+4:0]            f_res_o,
    output logic                                  valid_o,
    output logic                                  busy_o,
    output logic                                  isOverflow_o,
    output logic                                  isUnderflow_o,
    output logic                                  isToRound_o
);

    localparam int F_DW = LAMP_FLOAT_F_DW;
    localparam int E_DW = LAMP_FLOAT_E_DW;
    localparam int MW   = F_DW + 1;          // mantissa incl. hidden bit
    localparam int RW   = F_DW + 2;          // partial remainder
    localparam int QW   = F_DW + 4;          // quotient bits produced
    localparam int FW   = F_DW + 5;          // result mantissa bundle
    localparam int EW   = E_DW + 3;          // signed working exponent
    localparam int NW   = $clog2(1 + F_DW);
    localparam int CW   = $clog2(QW);
    localparam int SW   = $clog2(QW + 1);

    localparam logic signed [EW-1:0] E_BIAS_S = EW'(LAMP_FLOAT_E_BIAS);
    localparam logic signed [EW-1:0] E_MAX_S  = EW'(LAMP_FLOAT_E_MAX);
    localparam logic signed [EW-1:0] ONE_S    = EW'(1);
    localparam logic signed [EW-1:0] SH_MAX_S = EW'(QW);
    localparam logic [E_DW-1:0]      E_MAX_V  = E_DW'(LAMP_FLOAT_E_MAX);
    localparam logic [SW-1:0]        SH_MAX   = SW'(QW);
    localparam logic [CW-1:0]        CNT_LAST = CW'(F_DW + 3);
    localparam logic [FW-1:0]        NAN_F    = FW'(1) << (F_DW + 2);

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        NORM
    } state_t;

    typedef enum logic [1:0] {
        SPC_NONE,
        SPC_NAN,
        SPC_INF,
        SPC_ZERO
    } special_t;

    state_t                 r_state;
    state_t                 w_nextState;
    special_t               r_special;
    special_t               w_specialIn;

    logic                   r_sign;
    logic signed [EW-1:0]   r_exp;
    logic [RW-1:0]          r_rem;
    logic [MW-1:0]          r_div;
    logic [QW-1:0]          r_quo;
    logic [CW-1:0]          r_cnt;

    logic                   r_sRes;
    logic [E_DW-1:0]        r_eRes;
    logic [FW-1:0]          r_fRes;
    logic                   r_valid;
    logic                   r_ovf;
    logic                   r_unf;
    logic                   r_toRound;

    logic                   w_nan1;
    logic                   w_nan2;
    logic signed [EW-1:0]   w_eA;
    logic signed [EW-1:0]   w_eB;
    logic signed [EW-1:0]   w_eStart;

    logic                   w_geq;
    logic [RW-1:0]          w_diff;
    logic [RW-1:0]          w_remSel;
    logic [RW-1:0]          w_remNext;

    logic                   w_qMsb;
    logic [QW-2:0]          w_mant;
    logic                   w_sticky;
    logic signed [EW-1:0]   w_eNorm;
    logic [FW-1:0]          w_fNorm;
    logic signed [EW-1:0]   w_shWide;
    logic [SW-1:0]          w_shAmt;
    logic [FW-1:0]          w_fShift;
    logic [FW-1:0]          w_lostMask;
    logic [FW-1:0]          w_fUnf;

    logic                   w_sRes;
    logic [E_DW-1:0]        w_eRes;
    logic [FW-1:0]          w_fRes;
    logic                   w_ovf;
    logic                   w_unf;
    logic                   w_toRound;

    // Unbiased exponent difference, rebiased.  The nlz terms undo the
    // normalization shift the unpacker applied to subnormal operands.
    assign w_eA     = $signed({{(EW-E_DW-1){1'b0}}, extE_op1_i})
                    - $signed({{(EW-NW){1'b0}}, nlz_op1_i});
    assign w_eB     = $signed({{(EW-E_DW-1){1'b0}}, extE_op2_i})
                    - $signed({{(EW-NW){1'b0}}, nlz_op2_i});
    assign w_eStart = w_eA - w_eB + E_BIAS_S;

    assign w_nan1 = isSNAN_op1_i | isQNAN_op1_i;
    assign w_nan2 = isSNAN_op2_i | isQNAN_op2_i;

    // Classify the operation at start time.  Invalid cases are tested first.
    // After them, Inf/0 counts as infinity and 0/Inf counts as zero.
    always_comb begin
        w_specialIn = SPC_NONE;
        if (w_nan1 | w_nan2 | (isZ_op1_i & isZ_op2_i) | (isInf_op1_i & isInf_op2_i))
            w_specialIn = SPC_NAN;
        else if (isInf_op1_i | isZ_op2_i)
            w_specialIn = SPC_INF;
        else if (isZ_op1_i | isInf_op2_i)
            w_specialIn = SPC_ZERO;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_nextState;
    end

    // FSM next state.  Special results skip the iteration and go straight to
    // the output stage.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (doDiv_i) w_nextState = (w_specialIn == SPC_NONE) ? DIV : NORM;
            DIV:     if (r_cnt == CNT_LAST) w_nextState = NORM;
            NORM:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    assign busy_o = (r_state != IDLE);

    // Restoring step.  The remainder stays below twice the divisor, so
    // doubling it never loses a significant bit.
    assign w_geq     = (r_rem >= {1'b0, r_div});
    assign w_diff    = r_rem - {1'b0, r_div};
    assign w_remSel  = w_geq ? w_diff : r_rem;
    assign w_remNext = w_remSel << 1;

    // Operand latch and quotient iteration.  A start pulse is only accepted
    // in IDLE, so a pulse that arrives mid-operation has no effect.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_special <= SPC_NONE;
            r_sign    <= 1'b0;
            r_exp     <= '0;
            r_rem     <= '0;
            r_div     <= '0;
            r_quo     <= '0;
            r_cnt     <= '0;
        end else if (r_state == IDLE && doDiv_i) begin
            r_special <= w_specialIn;
            r_sign    <= s_op1_i ^ s_op2_i;
            r_exp     <= w_eStart;
            r_rem     <= {1'b0, extShF_op1_i};
            r_div     <= extShF_op2_i;
            r_quo     <= '0;
            r_cnt     <= '0;
        end else if (r_state == DIV) begin
            r_quo     <= {r_quo[QW-2:0], w_geq};
            r_rem     <= w_remNext;
            r_cnt     <= r_cnt + 1'b1;
        end
    end

    // Normalization.  The quotient of two normalized mantissas lies in
    // [0.5, 2).  When the top bit is clear, one extra bit is kept and the
    // exponent is decremented.  Every dropped bit and any nonzero remainder
    // folds into the sticky bit.
    assign w_qMsb   = r_quo[QW-1];
    assign w_mant   = w_qMsb ? r_quo[QW-1:1] : r_quo[QW-2:0];
    assign w_sticky = (w_qMsb & r_quo[0]) | (r_rem != '0);
    assign w_eNorm  = w_qMsb ? r_exp : r_exp - ONE_S;
    assign w_fNorm  = {1'b0, w_mant, w_sticky};

    // Underflow denormalization.  The shift amount is 1-e, capped at the
    // mantissa width.  The bits shifted out are ORed into the new S.
    assign w_shWide   = ONE_S - w_eNorm;
    assign w_shAmt    = (w_shWide > SH_MAX_S) ? SH_MAX : w_shWide[SW-1:0];
    assign w_fShift   = w_fNorm >> w_shAmt;
    assign w_lostMask = (FW'(1) << w_shAmt) - FW'(1);
    assign w_fUnf     = {w_fShift[FW-1:1], w_fShift[0] | (|(w_fNorm & w_lostMask))};

    // Final result selection.  Special results take priority.  For a regular
    // divide, overflow is checked before underflow.
    always_comb begin
        w_sRes    = r_sign;
        w_eRes    = '0;
        w_fRes    = '0;
        w_ovf     = 1'b0;
        w_unf     = 1'b0;
        w_toRound = 1'b0;
        case (r_special)
            SPC_NAN: begin
                w_sRes = 1'b0;
                w_eRes = E_MAX_V;
                w_fRes = NAN_F;
            end
            SPC_INF:  w_eRes = E_MAX_V;
            SPC_ZERO: w_eRes = '0;
            default: begin
                w_toRound = 1'b1;
                if (w_eNorm >= E_MAX_S) begin
                    w_ovf  = 1'b1;
                    w_eRes = E_MAX_V;
                end else if (w_eNorm[EW-1] || (w_eNorm == '0)) begin
                    w_unf  = 1'b1;
                    w_fRes = w_fUnf;
                end else begin
                    w_eRes = w_eNorm[E_DW-1:0];
                    w_fRes = w_fNorm;
                end
            end
        endcase
    end

    // Output registers load only in NORM and hold until the next completion.
    // valid_o is high only in the cycle after NORM.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sRes    <= 1'b0;
            r_eRes    <= '0;
            r_fRes    <= '0;
            r_valid   <= 1'b0;
            r_ovf     <= 1'b0;
            r_unf     <= 1'b0;
            r_toRound <= 1'b0;
        end else begin
            r_valid <= (r_state == NORM);
            if (r_state == NORM) begin
                r_sRes    <= w_sRes;
                r_eRes    <= w_eRes;
                r_fRes    <= w_fRes;
                r_ovf     <= w_ovf;
                r_unf     <= w_unf;
                r_toRound <= w_toRound;
            end
        end
    end

    assign s_res_o       = r_sRes;
    assign e_res_o       = r_eRes;
    assign f_res_o       = r_fRes;
    assign valid_o       = r_valid;
    assign isOverflow_o  = r_ovf;
    assign isUnderflow_o = r_unf;
    assign isToRound_o   = r_toRound;

endmodule

// File: tb/tb_lampfpu_div_seq.sv
// ---------------------------------------------------------------------------
// tb_lampfpu_div_seq
//
// Bench for the sequential bfloat16 divider.  Reference results come from
// plain integer division of the mantissas and from direct exponent
// arithmetic.  Directed cases use hand-computed constants.
// ---------------------------------------------------------------------------
module tb_lampfpu_div_seq;

    localparam int C_NORM = 0;
    localparam int C_ZERO = 1;
    localparam int C_INF  = 2;
    localparam int C_SNAN = 3;
    localparam int C_QNAN = 4;
    localparam int LAT_DIV  = 13;
    localparam int LAT_SPEC = 2;

    typedef struct packed {
        logic       s;
        logic [7:0] m;
        logic [8:0] e;
        logic [2:0] nlz;
        logic       z;
        logic       inf;
        logic       snan;
        logic       qnan;
    } opnd_t;

    typedef struct packed {
        logic        s;
        logic [7:0]  e;
        logic [11:0] f;
        logic        ovf;
        logic        unf;
        logic        rnd;
    } res_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        doDiv = 1'b0;
    logic        s1 = 1'b0, s2 = 1'b0;
    logic [7:0]  m1 = '0, m2 = '0;
    logic [8:0]  e1 = '0, e2 = '0;
    logic [2:0]  n1 = '0, n2 = '0;
    logic        z1 = 1'b0, i1 = 1'b0, sn1 = 1'b0, qn1 = 1'b0;
    logic        z2 = 1'b0, i2 = 1'b0, sn2 = 1'b0, qn2 = 1'b0;
    logic        s_res_o;
    logic [7:0]  e_res_o;
    logic [11:0] f_res_o;
    logic        valid_o, busy_o, isOverflow_o, isUnderflow_o, isToRound_o;

    int nVec   = 0;
    int nFail  = 0;
    int cycle  = 0;
    int tStart = 0;

    lampfpu_div_seq dut (
        .clk          (clk),
        .rst          (rst),
        .doDiv_i      (doDiv),
        .s_op1_i      (s1),
        .extShF_op1_i (m1),
        .extE_op1_i   (e1),
        .nlz_op1_i    (n1),
        .isZ_op1_i    (z1),
        .isInf_op1_i  (i1),
        .isSNAN_op1_i (sn1),
        .isQNAN_op1_i (qn1),
        .s_op2_i      (s2),
        .extShF_op2_i (m2),
        .extE_op2_i   (e2),
        .nlz_op2_i    (n2),
        .isZ_op2_i    (z2),
        .isInf_op2_i  (i2),
        .isSNAN_op2_i (sn2),
        .isQNAN_op2_i (qn2),
        .s_res_o      (s_res_o),
        .e_res_o      (e_res_o),
        .f_res_o      (f_res_o),
        .valid_o      (valid_o),
        .busy_o       (busy_o),
        .isOverflow_o (isOverflow_o),
        .isUnderflow_o(isUnderflow_o),
        .isToRound_o  (isToRound_o)
    );

    always #5 clk = ~clk;

    // Free-running edge counter used to measure latency.
    always @(posedge clk) cycle <= cycle + 1;

    function automatic res_t observed();
        return {s_res_o, e_res_o, f_res_o, isOverflow_o, isUnderflow_o, isToRound_o};
    endfunction

    function automatic opnd_t mkOp(input logic s, input logic [7:0] m, input logic [8:0] e,
                                   input logic [2:0] nlz, input int cls);
        opnd_t o;
        o      = '0;
        o.s    = s;
        o.m    = m;
        o.e    = e;
        o.nlz  = nlz;
        o.z    = (cls == C_ZERO);
        o.inf  = (cls == C_INF);
        o.snan = (cls == C_SNAN);
        o.qnan = (cls == C_QNAN);
        return o;
    endfunction

    function automatic opnd_t randOp();
        int r   = $urandom_range(0, 9);
        int cls = (r < 6) ? C_NORM : r - 5;
        return mkOp(1'($urandom), 8'h80 | 8'($urandom), 9'($urandom_range(1, 254)),
                    3'($urandom), cls);
    endfunction

    // Reference model.  The mantissa quotient is computed directly as
    // floor(m1 * 2^10 / m2), and the remainder supplies the sticky bit.
    function automatic res_t refDiv(input opnd_t a, input opnd_t b);
        res_t r;
        int   ma, mb, q, e, f, sh;
        bit   remNz, lost;
        r = '0;
        if (a.snan || a.qnan || b.snan || b.qnan || (a.z && b.z) || (a.inf && b.inf)) begin
            r.e = 8'hFF;
            r.f = 12'h200;
            return r;
        end
        r.s = a.s ^ b.s;
        if (a.inf || b.z) begin
            r.e = 8'hFF;
            return r;
        end
        if (a.z || b.inf) return r;
        r.rnd = 1'b1;
        ma    = int'(a.m);
        mb    = int'(b.m);
        q     = (ma * 1024) / mb;
        remNz = ((ma * 1024) % mb) != 0;
        e     = (int'(a.e) - int'(a.nlz)) - (int'(b.e) - int'(b.nlz)) + 127;
        if (q >= 1024) begin
            f = ((q / 2) * 2) + (((q % 2) != 0 || remNz) ? 1 : 0);
        end else begin
            f = q * 2 + (remNz ? 1 : 0);
            e = e - 1;
        end
        if (e >= 255) begin
            r.ovf = 1'b1;
            r.e   = 8'hFF;
            f     = 0;
        end else if (e <= 0) begin
            r.unf = 1'b1;
            sh    = 1 - e;
            if (sh > 11) sh = 11;
            lost  = (f % (1 << sh)) != 0;
            f     = (f >> sh) | (lost ? 1 : 0);
            r.e   = 8'h00;
        end else begin
            r.e = 8'(e);
        end
        r.f = 12'(f);
        return r;
    endfunction

    // Called just after a falling edge.  The operands and the start pulse are
    // sampled at the next rising edge.
    task automatic applyStimulus(input opnd_t a, input opnd_t b);
        s1 = a.s;  m1 = a.m;  e1 = a.e;  n1 = a.nlz;
        z1 = a.z;  i1 = a.inf; sn1 = a.snan; qn1 = a.qnan;
        s2 = b.s;  m2 = b.m;  e2 = b.e;  n2 = b.nlz;
        z2 = b.z;  i2 = b.inf; sn2 = b.snan; qn2 = b.qnan;
        doDiv = 1'b1;
        @(posedge clk);
        #1;
        doDiv  = 1'b0;
        tStart = cycle;
    endtask

    // Returns the start-to-valid latency in clock edges, or -1 if valid_o
    // does not appear within the cycle budget.
    task automatic waitValid(output int lat);
        bit found = 1'b0;
        lat = -1;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (valid_o) begin
                found = 1'b1;
                lat   = cycle - tStart + 1;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        nVec++;
        if (observed() !== res_t'(0)) begin
            nFail++;
            $display("[TB] FAIL reset outputs: got %h, expected %h", observed(), 24'h0);
        end
        nVec++;
        if (valid_o !== 1'b0) begin
            nFail++;
            $display("[TB] FAIL reset valid: got %b, expected 0", valid_o);
        end
        nVec++;
        if (busy_o !== 1'b0) begin
            nFail++;
            $display("[TB] FAIL reset busy: got %b, expected 0", busy_o);
        end
        rst = 1'b1;
    endtask

    task automatic test_directed();
        opnd_t a[3], b[3];
        res_t  ex[3];
        int    lat;
        a[0] = mkOp(0, 8'h80, 9'd127, 0, C_NORM); b[0] = mkOp(0, 8'h80, 9'd127, 0, C_NORM);
        ex[0] = {1'b0, 8'd127, 12'h400, 3'b001};
        a[1] = mkOp(0, 8'h80, 9'd127, 0, C_NORM); b[1] = mkOp(0, 8'hC0, 9'd128, 0, C_NORM);
        ex[1] = {1'b0, 8'd125, 12'h555, 3'b001};
        a[2] = mkOp(0, 8'hC0, 9'd129, 0, C_NORM); b[2] = mkOp(0, 8'h80, 9'd128, 0, C_NORM);
        ex[2] = {1'b0, 8'd128, 12'h600, 3'b001};
        for (int k = 0; k < 3; k++) begin
            applyStimulus(a[k], b[k]);
            nVec++;
            if (busy_o !== 1'b1) begin
                nFail++;
                $display("[TB] FAIL directed %0d busy: got %b, expected 1", k, busy_o);
            end
            waitValid(lat);
            nVec++;
            if (lat !== LAT_DIV) begin
                nFail++;
                $display("[TB] FAIL directed %0d latency: got %0d, expected %0d", k, lat, LAT_DIV);
            end
            nVec++;
            if (observed() !== ex[k]) begin
                nFail++;
                $display("[TB] FAIL directed %0d result: got %h, expected %h", k, observed(), ex[k]);
            end
            @(negedge clk);
            nVec++;
            if (valid_o !== 1'b0 || observed() !== ex[k]) begin
                nFail++;
                $display("[TB] FAIL directed %0d hold: got valid=%b res=%h, expected valid=0 res=%h",
                         k, valid_o, observed(), ex[k]);
            end
        end
    endtask

    task automatic test_specials();
        opnd_t a[7], b[7];
        res_t  ex[7];
        int    lat;
        opnd_t one = mkOp(0, 8'h80, 9'd127, 0, C_NORM);
        a[0] = mkOp(0, 8'h80, 9'd0, 0, C_ZERO);   b[0] = mkOp(0, 8'h80, 9'd0, 0, C_ZERO);
        ex[0] = {1'b0, 8'hFF, 12'h200, 3'b000};
        a[1] = mkOp(1, 8'h80, 9'd127, 0, C_NORM); b[1] = mkOp(0, 8'h80, 9'd0, 0, C_ZERO);
        ex[1] = {1'b1, 8'hFF, 12'h000, 3'b000};
        a[2] = mkOp(0, 8'h80, 9'd255, 0, C_INF);  b[2] = mkOp(1, 8'h80, 9'd255, 0, C_INF);
        ex[2] = {1'b0, 8'hFF, 12'h200, 3'b000};
        a[3] = mkOp(1, 8'hC1, 9'd255, 0, C_SNAN); b[3] = one;
        ex[3] = {1'b0, 8'hFF, 12'h200, 3'b000};
        a[4] = mkOp(0, 8'h80, 9'd0, 0, C_ZERO);   b[4] = mkOp(1, 8'hC0, 9'd128, 0, C_NORM);
        ex[4] = {1'b1, 8'h00, 12'h000, 3'b000};
        a[5] = mkOp(0, 8'h80, 9'd128, 0, C_NORM); b[5] = mkOp(1, 8'h80, 9'd255, 0, C_INF);
        ex[5] = {1'b1, 8'h00, 12'h000, 3'b000};
        a[6] = mkOp(1, 8'h80, 9'd255, 0, C_INF);  b[6] = mkOp(0, 8'h80, 9'd0, 0, C_ZERO);
        ex[6] = {1'b1, 8'hFF, 12'h000, 3'b000};
        for (int k = 0; k < 7; k++) begin
            applyStimulus(a[k], b[k]);
            waitValid(lat);
            nVec++;
            if (lat !== LAT_SPEC) begin
                nFail++;
                $display("[TB] FAIL special %0d latency: got %0d, expected %0d", k, lat, LAT_SPEC);
            end
            nVec++;
            if (observed() !== ex[k]) begin
                nFail++;
                $display("[TB] FAIL special %0d result: got %h, expected %h", k, observed(), ex[k]);
            end
        end
    endtask

    // Exponent boundaries around E_MAX and zero, including the spec examples.
    task automatic test_range_limits();
        opnd_t a[7], b[7];
        res_t  ex[7];
        int    lat;
        a[0] = mkOp(0, 8'h80, 9'd254, 0, C_NORM); b[0] = mkOp(0, 8'h80, 9'd1, 0, C_NORM);
        ex[0] = {1'b0, 8'hFF, 12'h000, 3'b101};
        a[1] = mkOp(1, 8'h80, 9'd254, 0, C_NORM); b[1] = mkOp(0, 8'h80, 9'd127, 0, C_NORM);
        ex[1] = {1'b1, 8'd254, 12'h400, 3'b001};
        a[2] = mkOp(0, 8'h80, 9'd255, 0, C_NORM); b[2] = mkOp(1, 8'h80, 9'd127, 0, C_NORM);
        ex[2] = {1'b1, 8'hFF, 12'h000, 3'b101};
        a[3] = mkOp(0, 8'h80, 9'd255, 0, C_NORM); b[3] = mkOp(0, 8'hC0, 9'd127, 0, C_NORM);
        ex[3] = {1'b0, 8'd254, 12'h555, 3'b001};
        a[4] = mkOp(0, 8'h80, 9'd1, 0, C_NORM);   b[4] = mkOp(0, 8'h80, 9'd200, 0, C_NORM);
        ex[4] = {1'b0, 8'd0, 12'h001, 3'b011};
        a[5] = mkOp(0, 8'h80, 9'd1, 0, C_NORM);   b[5] = mkOp(0, 8'h80, 9'd127, 0, C_NORM);
        ex[5] = {1'b0, 8'd1, 12'h400, 3'b001};
        a[6] = mkOp(0, 8'h80, 9'd1, 0, C_NORM);   b[6] = mkOp(0, 8'hC0, 9'd127, 0, C_NORM);
        ex[6] = {1'b0, 8'd0, 12'h2AB, 3'b011};
        for (int k = 0; k < 7; k++) begin
            applyStimulus(a[k], b[k]);
            waitValid(lat);
            nVec++;
            if (lat !== LAT_DIV) begin
                nFail++;
                $display("[TB] FAIL limit %0d latency: got %0d, expected %0d", k, lat, LAT_DIV);
            end
            nVec++;
            if (observed() !== ex[k]) begin
                nFail++;
                $display("[TB] FAIL limit %0d result: got %h, expected %h", k, observed(), ex[k]);
            end
        end
    endtask

    // Sweeps the denormalization shift from 0 up past saturation.
    task automatic test_underflow();
        opnd_t a, b;
        res_t  ex;
        int    lat;
        for (int k = 0; k < 14; k++) begin
            a  = mkOp(1'($urandom), 8'h80 | 8'($urandom), 9'd1, 0, C_NORM);
            b  = mkOp(1'($urandom), 8'h80 | 8'($urandom), 9'(127 + k), 0, C_NORM);
            ex = refDiv(a, b);
            applyStimulus(a, b);
            waitValid(lat);
            nVec++;
            if (lat !== LAT_DIV || observed() !== ex) begin
                nFail++;
                $display("[TB] FAIL underflow %0d: got lat=%0d res=%h, expected lat=%0d res=%h",
                         k, lat, observed(), LAT_DIV, ex);
            end
        end
    endtask

    task automatic test_random();
        opnd_t a, b;
        res_t  ex;
        int    lat, expLat;
        for (int k = 0; k < 80; k++) begin
            a      = randOp();
            b      = randOp();
            ex     = refDiv(a, b);
            expLat = ex.rnd ? LAT_DIV : LAT_SPEC;
            applyStimulus(a, b);
            waitValid(lat);
            nVec++;
            if (lat !== expLat) begin
                nFail++;
                $display("[TB] FAIL random %0d latency: got %0d, expected %0d", k, lat, expLat);
            end
            nVec++;
            if (observed() !== ex) begin
                nFail++;
                $display("[TB] FAIL random %0d result: a=%h b=%h got %h, expected %h",
                         k, a, b, observed(), ex);
            end
        end
    endtask

    task automatic test_ignore_busy();
        opnd_t a = mkOp(0, 8'hC0, 9'd129, 0, C_NORM);
        opnd_t b = mkOp(0, 8'h80, 9'd128, 0, C_NORM);
        res_t  ex = {1'b0, 8'd128, 12'h600, 3'b001};
        int    lat;
        int    extra = 0;
        applyStimulus(a, b);
        repeat (4) @(negedge clk);
        s1 = 1'b1; m1 = 8'h80; e1 = 9'd10; s2 = 1'b0; m2 = 8'hC0; e2 = 9'd40;
        doDiv = 1'b1;
        @(negedge clk);
        doDiv = 1'b0;
        waitValid(lat);
        nVec++;
        if (lat !== LAT_DIV || observed() !== ex) begin
            nFail++;
            $display("[TB] FAIL ignore_busy result: got lat=%0d res=%h, expected lat=%0d res=%h",
                     lat, observed(), LAT_DIV, ex);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (valid_o) extra++;
        end
        nVec++;
        if (extra !== 0) begin
            nFail++;
            $display("[TB] FAIL ignore_busy extra valid: got %0d, expected 0", extra);
        end
    endtask

    task automatic test_back_to_back();
        opnd_t a = mkOp(0, 8'h80, 9'd127, 0, C_NORM);
        opnd_t b = mkOp(0, 8'hC0, 9'd128, 0, C_NORM);
        opnd_t c = mkOp(1, 8'hC0, 9'd129, 0, C_NORM);
        opnd_t d = mkOp(0, 8'h80, 9'd128, 0, C_NORM);
        res_t  ex1 = {1'b0, 8'd125, 12'h555, 3'b001};
        res_t  ex2 = {1'b1, 8'd128, 12'h600, 3'b001};
        int    lat;
        applyStimulus(a, b);
        waitValid(lat);
        nVec++;
        if (lat !== LAT_DIV || observed() !== ex1) begin
            nFail++;
            $display("[TB] FAIL b2b first: got lat=%0d res=%h, expected lat=%0d res=%h",
                     lat, observed(), LAT_DIV, ex1);
        end
        applyStimulus(c, d);
        waitValid(lat);
        nVec++;
        if (lat !== LAT_DIV || observed() !== ex2) begin
            nFail++;
            $display("[TB] FAIL b2b second: got lat=%0d res=%h, expected lat=%0d res=%h",
                     lat, observed(), LAT_DIV, ex2);
        end
    endtask

    task automatic test_reset_mid_div();
        opnd_t a = mkOp(0, 8'hC0, 9'd129, 0, C_NORM);
        opnd_t b = mkOp(0, 8'h80, 9'd128, 0, C_NORM);
        res_t  ex = {1'b0, 8'd128, 12'h600, 3'b001};
        int    lat;
        int    extra = 0;
        applyStimulus(a, b);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        nVec++;
        if (observed() !== res_t'(0) || busy_o !== 1'b0 || valid_o !== 1'b0) begin
            nFail++;
            $display("[TB] FAIL reset_mid_div state: got res=%h busy=%b valid=%b, expected 0 0 0",
                     observed(), busy_o, valid_o);
        end
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (valid_o) extra++;
        end
        nVec++;
        if (extra !== 0) begin
            nFail++;
            $display("[TB] FAIL reset_mid_div stray valid: got %0d, expected 0", extra);
        end
        applyStimulus(a, b);
        waitValid(lat);
        nVec++;
        if (lat !== LAT_DIV || observed() !== ex) begin
            nFail++;
            $display("[TB] FAIL reset_mid_div recovery: got lat=%0d res=%h, expected lat=%0d res=%h",
                     lat, observed(), LAT_DIV, ex);
        end
    endtask

    initial begin
        $display("[TB] starting lampfpu_div_seq bench");
        test_reset();
        test_directed();
        test_specials();
        test_range_limits();
        test_underflow();
        test_random();
        test_ignore_busy();
        test_back_to_back();
        test_reset_mid_div();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

endmodule

// File: doc/lampfpu_div_seq.md
Name: lampfpu_div_seq

Overview:
Iterative restoring floating-point divider, the inverse-operation companion of the FPU multiplier. It consumes the same unpacked operand bundle: sign, extended shifted mantissa, extended exponent, leading-zero count and class flags. It produces the same pre-rounding result bundle (s/e/f with G,R,S, plus overflow, underflow and isToRound), so the shared rounding/packing stage takes it unchanged. One quotient bit per cycle; busy while iterating.

Parameters:
LAMP_FLOAT_F_DW, 7, fraction width (bfloat16)
LAMP_FLOAT_E_DW, 8, exponent width
LAMP_FLOAT_E_BIAS, 127, exponent bias
LAMP_FLOAT_E_MAX, 255, all-ones exponent (Inf/NaN)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low (rst==0 resets)
doDiv_i  in  1  start pulse; operands sampled same cycle
s_op1_i / s_op2_i  in  1  dividend / divisor sign
extShF_op1_i / extShF_op2_i  in  1+F_DW  normalized mantissa, hidden bit at MSB
extE_op1_i / extE_op2_i  in  E_DW+1  extended exponent
nlz_op1_i / nlz_op2_i  in  clog2(1+F_DW)  normalization shift already applied
isZ/isInf/isSNAN/isQNAN_op1_i, _op2_i  in  1 each  operand class
s_res_o  out  1  result sign
e_res_o  out  E_DW  result exponent
f_res_o  out  F_DW+5  {ovf(0), hidden, F, G, R, S}
valid_o  out  1  one-cycle result strobe
busy_o  out  1  division in progress
isOverflow_o / isUnderflow_o / isToRound_o  out  1 each  flags for the rounder

Behaviour:
- Reset (rst==0 at posedge): state IDLE. All outputs 0. Any in-flight operation is aborted with no valid_o.
- FSM: IDLE -> DIV on doDiv_i with a non-special result. IDLE -> NORM on doDiv_i with a special result. DIV -> NORM when cnt==F_DW+3. NORM -> IDLE, asserting valid_o.
- doDiv_i while busy_o=1 is ignored. busy_o=1 in DIV and NORM.
- Latency from doDiv_i to valid_o: F_DW+6 cycles for a normal divide (13 for bfloat16); 2 cycles for a special result.
- On start, latch the sign s1^s2.
- On start, latch the exponent as signed, width E_DW+3: e = (extE1-nlz1) - (extE2-nlz2) + BIAS.
- On start, latch the remainder R=extShF_op1 (width F_DW+2) and divisor D=extShF_op2; clear cnt and q.
- DIV step: if R>=D then q={q,1} and R=(R-D)<<1; otherwise q={q,0} and R=R<<1. Produces F_DW+4 quotient bits (11), MSB first.
- NORM:
  - If q[MSB]==1: mantissa = q[MSB:1] (hidden, F, G, R) and S = q[0] | (R!=0).
  - If q[MSB]==0: mantissa = q[MSB-1:0], S = (R!=0), and e = e-1.
  - f = {1'b0, mantissa, S}.
- Overflow: e >= E_MAX gives isOverflow=1, e_res=E_MAX, f_res=0.
- Underflow: e <= 0 gives a right shift of f by 1-e, saturating at F_DW+4. Shifted-out bits are ORed into S; e_res=0 and isUnderflow=1. A shift >= F_DW+4 yields f={0..0,S}.
- Special results, isToRound=0, f_res=0:
  - Either operand NaN, 0/0, or Inf/Inf: QNaN (e=E_MAX, f fraction MSB set), sign 0.
  - Inf/x or x/0 with x nonzero finite: Inf with sign s1^s2.
  - 0/x or x/Inf: zero with sign s1^s2.
- Otherwise isToRound=1.
- Output registers update only in NORM. They hold their value until the next completion.

Test Plan:
- 1.0/1.0 (extShF 0x80, extE 127 both, nlz 0) -> 13 cycles later: valid_o=1 for one cycle, s=0, e=127, f=0x400, no flags, isToRound=1.
- 1.0/3.0 (op2 extShF 0xC0, extE 128) -> e=125, f=0x555 (G=1, S=1); 6.0/2.0 (0xC0/129 over 0x80/128) -> e=128, f=0x600.
- 0/0 -> QNaN, isToRound=0, latency 2. -1.0/+0 -> s=1, e=255, f=0 (Inf). Inf/Inf -> QNaN.
- Overflow: op1 extE 254, op2 extE 1, both mantissa 0x80 -> isOverflow=1, e=255, f=0.
- Underflow: op1 extE 1, op2 extE 200 -> e_res=0, isUnderflow=1; all shifted-out bits reflected in S.
- Control cases:
  - Second doDiv_i mid-DIV -> ignored; first result correct; no extra valid_o.
  - rst=0 mid-DIV -> outputs 0, busy_o=0, no valid_o.
  - Back-to-back starts on the cycle after valid_o -> both results correct.
